// File: rtl/uart_tx_ctrl_if.sv
// UART transmit controller bus
// Frame request inputs and mux-control outputs
interface uart_tx_ctrl_if #(
  parameter int DATA_WIDTH = 8
);

  logic [DATA_WIDTH-1:0] P_DATA;
  logic                  Data_Valid;
  logic                  PAR_EN;
  logic                  PAR_TYP;
  logic [1:0]            mux_sel;
  logic                  ser_data;
  logic                  par_bit;
  logic                  busy;

  modport master (
    output P_DATA,
    output Data_Valid,
    output PAR_EN,
    output PAR_TYP,
    input  mux_sel,
    input  ser_data,
    input  par_bit,
    input  busy
  );

  modport slave (
    input  P_DATA,
    input  Data_Valid,
    input  PAR_EN,
    input  PAR_TYP,
    output mux_sel,
    output ser_data,
    output par_bit,
    output busy
  );

endinterface

// File: rtl/uart_tx_ctrl.sv
// UART transmit frame sequencer
// Drives the output mux select, serial data and parity bit
module uart_tx_ctrl #(
  parameter int DATA_WIDTH = 8
) (
  input logic           clk,
  input logic           RST,
  uart_tx_ctrl_if.slave bus
);

  localparam int CW = $clog2(DATA_WIDTH);

  typedef logic [CW-1:0] cnt_t;

  localparam cnt_t LAST = cnt_t'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_t;

  state_t                state_q;
  state_t                state_d;
  logic                  load;
  cnt_t                  cnt_q;
  logic [DATA_WIDTH-1:0] data_q;
  logic                  par_en_q;
  logic                  par_typ_q;
  logic [1:0]            mux_sel;
  logic                  ser_data;
  logic                  busy;

  // State register
  always_ff @(posedge clk) begin
    if (!RST) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state; requests only accepted from IDLE or STOP
  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.Data_Valid) begin
          load    = 1'b1;
          state_d = START;
        end
      end
      START: begin
        state_d = DATA;
      end
      DATA: begin
        if (cnt_q == LAST) begin
          state_d = par_en_q ? PARITY : STOP;
        end
      end
      PARITY: begin
        state_d = STOP;
      end
      STOP: begin
        if (bus.Data_Valid) begin
          load    = 1'b1;
          state_d = START;
        end else begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Latch frame data and configuration at request acceptance
  always_ff @(posedge clk) begin
    if (!RST) begin
      data_q    <= '0;
      par_en_q  <= 1'b0;
      par_typ_q <= 1'b0;
    end else if (load) begin
      data_q    <= bus.P_DATA;
      par_en_q  <= bus.PAR_EN;
      par_typ_q <= bus.PAR_TYP;
    end
  end

  // Bit counter, runs only while in DATA
  always_ff @(posedge clk) begin
    if (!RST) begin
      cnt_q <= '0;
    end else if (state_q != DATA) begin
      cnt_q <= '0;
    end else if (cnt_q == LAST) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + cnt_t'(1);
    end
  end

  // Output decode from registered state
  always_comb begin
    mux_sel  = 2'b01;
    ser_data = 1'b0;
    busy     = 1'b1;
    unique case (1'b1)
      (state_q == START): begin
        mux_sel = 2'b00;
      end
      (state_q == DATA): begin
        mux_sel  = 2'b10;
        ser_data = data_q[cnt_q];
      end
      (state_q == PARITY): begin
        mux_sel = 2'b11;
      end
      (state_q == STOP): begin
        mux_sel = 2'b01;
      end
      default: begin
        busy = 1'b0;
      end
    endcase
  end

  assign bus.mux_sel  = mux_sel;
  assign bus.ser_data = ser_data;
  assign bus.busy     = busy;
  assign bus.par_bit  = (^data_q) ^ par_typ_q;

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Bench for uart_tx_ctrl
// Scoreboard of per-cycle expected mux/data/parity/busy records
module tb_uart_tx_ctrl;

  logic clk = 1'b0;
  logic RST;

  always #5 clk = ~clk;

  uart_tx_ctrl_if #(.DATA_WIDTH(8)) b8 ();
  uart_tx_ctrl_if #(.DATA_WIDTH(7)) b7 ();

  uart_tx_ctrl #(.DATA_WIDTH(8)) u8 (
    .clk(clk),
    .RST(RST),
    .bus(b8)
  );

  uart_tx_ctrl #(.DATA_WIDTH(7)) u7 (
    .clk(clk),
    .RST(RST),
    .bus(b7)
  );

  typedef struct {
    logic [1:0] mux;
    logic       ser;
    logic       par;
    logic       busy;
    string      nm;
  } exp_t;

  typedef struct {
    logic [7:0] d;
    logic       pe;
    logic       pt;
    logic       par;
    int         len;
    string      nm;
  } vec_t;

  exp_t sb8[$];
  exp_t sb7[$];
  vec_t vt[6];
  int   n_vec = 0;
  int   n_bad = 0;

  task automatic chk(exp_t e, logic [1:0] m,
                     logic s, logic p, logic b);
    n_vec++;
    if (m !== e.mux || s !== e.ser ||
        p !== e.par || b !== e.busy) begin
      n_bad++;
      $display("FAIL %s: got mux_sel=%b ser_data=%b par_bit=%b busy=%b, want %b %b %b %b",
               e.nm, m, s, p, b, e.mux, e.ser, e.par, e.busy);
    end
  endtask

  task automatic cmp_int(string nm, int got, int want);
    n_vec++;
    if (got != want) begin
      n_bad++;
      $display("FAIL %s: got %0d want %0d", nm, got, want);
    end
  endtask

  task automatic tick();
    exp_t e;
    @(posedge clk);
    #1;
    if (sb8.size() > 0) begin
      e = sb8.pop_front();
      chk(e, b8.mux_sel, b8.ser_data, b8.par_bit, b8.busy);
    end
    if (sb7.size() > 0) begin
      e = sb7.pop_front();
      chk(e, b7.mux_sel, b7.ser_data, b7.par_bit, b7.busy);
    end
  endtask

  task automatic push(int w, logic [1:0] m, logic s,
                      logic p, logic b, string nm);
    exp_t e;
    e.mux  = m;
    e.ser  = s;
    e.par  = p;
    e.busy = b;
    e.nm   = nm;
    if (w == 7) sb7.push_back(e);
    else sb8.push_back(e);
  endtask

  task automatic push_frame(int w, logic [8:0] d, logic pe,
                            logic par, string nm);
    push(w, 2'b00, 1'b0, par, 1'b1, {nm, " start"});
    for (int i = 0; i < w; i++) begin
      push(w, 2'b10, d[i], par, 1'b1,
           $sformatf("%s d%0d", nm, i));
    end
    if (pe) push(w, 2'b11, 1'b0, par, 1'b1, {nm, " parity"});
    push(w, 2'b01, 1'b0, par, 1'b1, {nm, " stop"});
  endtask

  task automatic drive8(logic [7:0] d, logic pe,
                        logic pt, logic dv);
    b8.P_DATA     = d;
    b8.PAR_EN     = pe;
    b8.PAR_TYP    = pt;
    b8.Data_Valid = dv;
  endtask

  initial begin
    int nb;
    int nd;

    vt[0] = '{8'hA5, 1'b0, 1'b0, 1'b0, 10, "a5_nopar"};
    vt[1] = '{8'hA5, 1'b1, 1'b0, 1'b0, 11, "a5_even"};
    vt[2] = '{8'hA5, 1'b1, 1'b1, 1'b1, 11, "a5_odd"};
    vt[3] = '{8'h3C, 1'b1, 1'b1, 1'b1, 11, "3c_odd"};
    vt[4] = '{8'h01, 1'b1, 1'b0, 1'b1, 11, "01_even"};
    vt[5] = '{8'hFE, 1'b0, 1'b1, 1'b0, 10, "fe_nopar"};

    RST = 1'b0;
    drive8(8'h00, 1'b0, 1'b0, 1'b0);
    b7.P_DATA     = '0;
    b7.PAR_EN     = 1'b0;
    b7.PAR_TYP    = 1'b0;
    b7.Data_Valid = 1'b0;
    tick();
    tick();
    push(8, 2'b01, 1'b0, 1'b0, 1'b0, "reset8");
    push(7, 2'b01, 1'b0, 1'b0, 1'b0, "reset7");
    tick();
    RST = 1'b1;
    tick();

    // table-driven single frames
    for (int k = 0; k < 6; k++) begin
      drive8(vt[k].d, vt[k].pe, vt[k].pt, 1'b1);
      push_frame(8, {1'b0, vt[k].d}, vt[k].pe,
                 vt[k].par, vt[k].nm);
      push(8, 2'b01, 1'b0, vt[k].par, 1'b0,
           {vt[k].nm, " idle"});
      tick();
      drive8(~vt[k].d, ~vt[k].pe, ~vt[k].pt, 1'b0);
      nb = b8.busy ? 1 : 0;
      for (int c = 0; c < 20; c++) begin
        tick();
        if (!b8.busy) break;
        nb++;
      end
      cmp_int({vt[k].nm, " busy_len"}, nb, vt[k].len);
      sb8.delete();
    end

    // back-to-back frames with Data_Valid held high
    drive8(8'h3C, 1'b0, 1'b0, 1'b1);
    push_frame(8, 9'h03C, 1'b0, 1'b0, "b2b_1");
    push_frame(8, 9'h0C3, 1'b0, 1'b0, "b2b_2");
    push(8, 2'b01, 1'b0, 1'b0, 1'b0, "b2b idle");
    tick();
    b8.P_DATA = 8'hC3;
    repeat (9) tick();
    tick();
    b8.Data_Valid = 1'b0;
    repeat (9) tick();
    tick();

    // request during DATA is ignored
    drive8(8'h00, 1'b0, 1'b0, 1'b1);
    push_frame(8, 9'h000, 1'b0, 1'b0, "ign");
    repeat (3) push(8, 2'b01, 1'b0, 1'b0, 1'b0, "ign idle");
    tick();
    b8.Data_Valid = 1'b0;
    repeat (2) tick();
    drive8(8'hFF, 1'b0, 1'b0, 1'b1);
    tick();
    b8.Data_Valid = 1'b0;
    repeat (6) tick();
    repeat (3) tick();

    // reset during DATA bit 3
    drive8(8'hA5, 1'b1, 1'b1, 1'b1);
    push(8, 2'b00, 1'b0, 1'b1, 1'b1, "abort start");
    push(8, 2'b10, 1'b1, 1'b1, 1'b1, "abort d0");
    push(8, 2'b10, 1'b0, 1'b1, 1'b1, "abort d1");
    push(8, 2'b10, 1'b1, 1'b1, 1'b1, "abort d2");
    push(8, 2'b10, 1'b0, 1'b1, 1'b1, "abort d3");
    push(8, 2'b01, 1'b0, 1'b0, 1'b0, "abort rst");
    tick();
    b8.Data_Valid = 1'b0;
    repeat (4) tick();
    RST = 1'b0;
    drive8(8'hFF, 1'b1, 1'b1, 1'b1);
    tick();
    RST = 1'b1;
    b8.Data_Valid = 1'b0;
    push(8, 2'b01, 1'b0, 1'b0, 1'b0, "post rst idle");
    tick();
    drive8(8'h81, 1'b0, 1'b0, 1'b1);
    push_frame(8, 9'h081, 1'b0, 1'b0, "x81");
    push(8, 2'b01, 1'b0, 1'b0, 1'b0, "x81 idle");
    tick();
    b8.Data_Valid = 1'b0;
    repeat (9) tick();
    tick();

    // seven-bit frame with odd parity
    b7.P_DATA     = 7'h55;
    b7.PAR_EN     = 1'b1;
    b7.PAR_TYP    = 1'b1;
    b7.Data_Valid = 1'b1;
    push_frame(7, 9'h055, 1'b1, 1'b1, "w7");
    push(7, 2'b01, 1'b0, 1'b1, 1'b0, "w7 idle");
    tick();
    b7.Data_Valid = 1'b0;
    nb = b7.busy ? 1 : 0;
    nd = 0;
    for (int c = 0; c < 20; c++) begin
      tick();
      if (!b7.busy) break;
      nb++;
      if (b7.mux_sel == 2'b10) nd++;
    end
    cmp_int("w7 busy_len", nb, 10);
    cmp_int("w7 data_cycles", nd, 7);
    sb7.delete();

    cmp_int("sb drain", sb8.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_bad);
    $finish;
  end

endmodule
